// File: rtl/modport_axi_pkg.sv
// Shared types, constants and burst address arithmetic for the AXI4 RAM slave.
package modport_axi_pkg;

  localparam int ID_W          = 8;
  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 32;
  localparam int STRB_W        = DATA_W / 8;
  localparam int DEF_MEM_WORDS = 1024;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Address of the beat after 'addr'; reserved bursts step like INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0]        len,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] step, beats, wrap_sz, base, incr;
    step    = ADDR_ONE << size;
    beats   = {{(ADDR_W-8){1'b0}}, len} + ADDR_ONE;
    wrap_sz = beats << size;
    base    = addr & ~(wrap_sz - ADDR_ONE);
    incr    = addr + step;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (incr == base + wrap_sz) ? base : incr;
      default:     next_addr = incr;
    endcase
  endfunction

endpackage

// File: rtl/modport_axi_slave_if.sv
// AXI4 bus bundle between a master and the RAM slave.
interface modport_axi_slave_if;
  import modport_axi_pkg::*;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid, awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast, wvalid, wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid, bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid, arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/modport_axi_ram.sv
// Byte-enabled single-clock RAM: one write port, one registered read port with enable.
module modport_axi_ram
  import modport_axi_pkg::*;
#(
  parameter int WORDS = DEF_MEM_WORDS,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: non-blocking update of r_mem means a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/modport_axi_slave.sv
// AXI4 slave over an internal RAM; independent write and read FSMs, one burst each in flight.
module modport_axi_slave
  import modport_axi_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input logic                clk,
  input logic                rst,
  modport_axi_slave_if.slave s_axi
);

  localparam int                RAM_AW    = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0]   MEM_BYTES = (ADDR_W+1)'(4 * MEM_WORDS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < MEM_BYTES;
  endfunction

  w_state_t          r_wstate;
  logic              r_awready, r_wready, r_bvalid, r_werr;
  logic [ID_W-1:0]   r_bid;
  logic [1:0]        r_bresp, r_awburst;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_awlen, r_wcnt;
  logic [2:0]        r_awsize;

  r_state_t          r_rstate;
  logic              r_arready, r_rvalid, r_rlast, r_roor, r_rberr;
  logic [ID_W-1:0]   r_rid;
  logic [1:0]        r_rresp, r_arburst;
  logic [ADDR_W-1:0] r_raddr;
  logic [7:0]        r_arlen, r_rcnt;
  logic [2:0]        r_arsize;

  logic              w_wbeat, w_werr_now, w_ram_we, w_ar_hs, w_r_hs, w_ram_re, w_unused;
  logic [ADDR_W-1:0] w_rnext;
  logic [RAM_AW-1:0] w_rd_word;
  logic [DATA_W-1:0] w_ram_q;

  assign w_wbeat    = r_wready && s_axi.wvalid;
  assign w_werr_now = r_werr || !in_range(r_waddr);
  assign w_ram_we   = w_wbeat && in_range(r_waddr) && (r_awsize <= 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= BURST_FIXED;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_awready && s_axi.awvalid) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= s_axi.awid;
            r_waddr   <= s_axi.awaddr;
            r_awlen   <= s_axi.awlen;
            r_awsize  <= s_axi.awsize;
            r_awburst <= s_axi.awburst;
            r_wcnt    <= '0;
            r_werr    <= (s_axi.awsize > 3'd2) || (s_axi.awburst == BURST_RSVD);
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          // Beat count ends the burst; wlast is ignored.
          if (w_wbeat) begin
            r_waddr <= next_addr(r_waddr, r_awlen, r_awsize, r_awburst);
            r_wcnt  <= r_wcnt + 8'd1;
            r_werr  <= w_werr_now;
            if (r_wcnt == r_awlen) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_werr_now ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // The RAM is fetched one beat ahead so rdata is ready the cycle rvalid rises.
  assign w_ar_hs   = r_arready && s_axi.arvalid;
  assign w_r_hs    = r_rvalid && s_axi.rready;
  assign w_rnext   = next_addr(r_raddr, r_arlen, r_arsize, r_arburst);
  assign w_ram_re  = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_rd_word = w_ar_hs ? s_axi.araddr[RAM_AW+1:2] : w_rnext[RAM_AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= RESP_OKAY;
      r_roor    <= 1'b0;
      r_rberr   <= 1'b0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= BURST_FIXED;
      r_rcnt    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rid     <= s_axi.arid;
            r_raddr   <= s_axi.araddr;
            r_arlen   <= s_axi.arlen;
            r_arsize  <= s_axi.arsize;
            r_arburst <= s_axi.arburst;
            r_rcnt    <= '0;
            r_rlast   <= (s_axi.arlen == 8'd0);
            r_rberr   <= (s_axi.arsize > 3'd2) || (s_axi.arburst == BURST_RSVD);
            r_roor    <= !in_range(s_axi.araddr);
            r_rresp   <= (!in_range(s_axi.araddr) || (s_axi.arsize > 3'd2) ||
                          (s_axi.arburst == BURST_RSVD)) ? RESP_SLVERR : RESP_OKAY;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= w_rnext;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rlast <= (r_rcnt + 8'd1 == r_arlen);
              r_roor  <= !in_range(w_rnext);
              r_rresp <= (r_rberr || !in_range(w_rnext)) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  modport_axi_ram #(.WORDS(MEM_WORDS), .AW(RAM_AW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_waddr[RAM_AW+1:2]),
    .i_wstrb (s_axi.wstrb),
    .i_wdata (s_axi.wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_rd_word),
    .o_rdata (w_ram_q)
  );

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rid     = r_rid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = (r_rvalid && !r_roor) ? w_ram_q : '0;

  assign w_unused = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.wlast,
                      s_axi.arlock, s_axi.arcache, s_axi.arprot};

endmodule

// File: tb/tb_modport_axi_slave.sv
// Directed bench for modport_axi_slave: a byte-level memory model and per-cycle R/B comparison.
module tb_modport_axi_slave;
  import modport_axi_pkg::*;

  localparam int TMO       = 64;
  localparam int MEM_BYTES = 4 * 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modport_axi_slave_if bus ();
  modport_axi_slave #(.MEM_WORDS(1024)) dut (.clk(clk), .rst(rst), .s_axi(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic [31:0] m_mem [1024];
  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [31:0] got_r[$];
  logic [1:0]  last_bresp;
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];

  // Beat address from the burst definition: start + i*step, folded into the wrap window.
  function automatic logic [15:0] beat_addr(input logic [15:0] start, input int len,
                                            input int size, input int burst, input int i);
    int step, span, base;
    step = 1 << size;
    span = (len + 1) * step;
    base = (int'(start) / span) * span;
    if (burst == 0) return start;
    if (burst == 2) return 16'(base + (int'(start) - base + i * step) % span);
    return 16'(int'(start) + i * step);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_r.delete();
      exp_b.delete();
    end else begin
      if (bus.rvalid) begin
        if (exp_r.size() == 0) check("r_unexpected", 64'(bus.rvalid), 64'd0);
        else begin
          check("rid",   64'(bus.rid),   64'(exp_r[0].id));
          check("rdata", 64'(bus.rdata), 64'(exp_r[0].data));
          check("rresp", 64'(bus.rresp), 64'(exp_r[0].resp));
          check("rlast", 64'(bus.rlast), 64'(exp_r[0].last));
          if (bus.rready) begin
            got_r.push_back(bus.rdata);
            void'(exp_r.pop_front());
          end
        end
      end
      if (bus.bvalid) begin
        if (exp_b.size() == 0) check("b_unexpected", 64'(bus.bvalid), 64'd0);
        else begin
          check("bid",   64'(bus.bid),   64'(exp_b[0].id));
          check("bresp", 64'(bus.bresp), 64'(exp_b[0].resp));
          if (bus.bready) begin
            last_bresp = bus.bresp;
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  task automatic axi_write(input logic [7:0] id, input logic [15:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
    bit          err;
    logic [15:0] a;
    int          t;
    err = (size > 3'd2) || (burst == BURST_RSVD);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, int'(size), int'(burst), i);
      if (int'(a) >= MEM_BYTES) err = 1'b1;
      else if (size <= 3'd2)
        for (int b = 0; b < 4; b++)
          if (wstb[i][b]) m_mem[a[11:2]][8*b +: 8] = wdat[i][8*b +: 8];
    end
    exp_b.push_back('{id: id, resp: err ? RESP_SLVERR : RESP_OKAY});

    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.awready && t < TMO);
    check("awready_wait", 64'(bus.awready), 64'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wdata = wdat[i]; bus.wstrb = wstb[i]; bus.wlast = (i == len); bus.wvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.wready && t < TMO);
      check("wready_wait", 64'(bus.wready), 64'd1);
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.bvalid && t < TMO);
    check("bvalid_wait", 64'(bus.bvalid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [15:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int stall_n);
    bit          err;
    logic [15:0] a;
    int          t;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, int'(size), int'(burst), i);
      err = (int'(a) >= MEM_BYTES) || (size > 3'd2) || (burst == BURST_RSVD);
      exp_r.push_back('{id: id,
                        data: (int'(a) >= MEM_BYTES) ? 32'h0 : m_mem[a[11:2]],
                        resp: err ? RESP_SLVERR : RESP_OKAY,
                        last: (i == len)});
    end
    got_r.delete();

    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.arready && t < TMO);
    check("arready_wait", 64'(bus.arready), 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == stall_beat) begin
        bus.rready = 1'b0;
        repeat (stall_n) begin @(posedge clk); #1; end
      end
      bus.rready = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.rvalid && t < TMO);
      check("rvalid_wait", 64'(bus.rvalid), 64'd1);
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_wready",  64'(bus.wready),  64'd0);
    check("rst_bvalid",  64'(bus.bvalid),  64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_rvalid",  64'(bus.rvalid),  64'd0);
    check("rst_rlast",   64'(bus.rlast),   64'd0);
    check("rst_bid",     64'(bus.bid),     64'd0);
    check("rst_bresp",   64'(bus.bresp),   64'd0);
    check("rst_rid",     64'(bus.rid),     64'd0);
    check("rst_rdata",   64'(bus.rdata),   64'd0);
    check("rst_rresp",   64'(bus.rresp),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_awready", 64'(bus.awready), 64'd1);
    check("post_rst_arready", 64'(bus.arready), 64'd1);
    @(posedge clk); #1;

    // Single beat
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    axi_write(8'h11, 16'h0010, 0, 3'd2, BURST_INCR);
    check("single_bresp", 64'(last_bresp), 64'd0);
    check("pin_single_model", 64'(m_mem[4]), 64'hDEADBEEF);
    axi_read(8'h21, 16'h0010, 0, 3'd2, BURST_INCR, -1, 0);
    check("single_rdata", 64'(got_r[0]), 64'hDEADBEEF);

    // INCR burst of four
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    axi_write(8'h12, 16'h0100, 3, 3'd2, BURST_INCR);
    axi_read(8'h22, 16'h0100, 3, 3'd2, BURST_INCR, -1, 0);
    check("incr_count", 64'(got_r.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("incr_order", 64'(got_r[i]), 64'(i + 1));

    // WRAP read with a 3-cycle stall on beat 1
    check("pin_wrap_a2", 64'(beat_addr(16'h0108, 3, 2, 2, 2)), 64'h0100);
    axi_read(8'h23, 16'h0108, 3, 3'd2, BURST_WRAP, 1, 3);
    check("wrap_count", 64'(got_r.size()), 64'd4);
    check("wrap_b0", 64'(got_r[0]), 64'd3);
    check("wrap_b1", 64'(got_r[1]), 64'd4);
    check("wrap_b2", 64'(got_r[2]), 64'd1);
    check("wrap_b3", 64'(got_r[3]), 64'd2);

    // Partial strobe
    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    axi_write(8'h13, 16'h0020, 0, 3'd2, BURST_INCR);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    axi_write(8'h14, 16'h0020, 0, 3'd2, BURST_INCR);
    check("pin_strobe_model", 64'(m_mem[8]), 64'h11BB33DD);
    axi_read(8'h24, 16'h0020, 0, 3'd2, BURST_INCR, -1, 0);
    check("strobe_rdata", 64'(got_r[0]), 64'h11BB33DD);

    // Out of range, and a burst that crosses the top of memory
    wdat[0] = 32'h0BADF00D; wstb[0] = 4'hF;
    axi_write(8'h15, 16'h1000, 0, 3'd2, BURST_INCR);
    check("oor_bresp", 64'(last_bresp), 64'd2);
    axi_read(8'h25, 16'h1000, 0, 3'd2, BURST_INCR, 0, 2);
    wdat[0] = 32'hCAFEF00D; wdat[1] = 32'h12345678; wstb[0] = 4'hF; wstb[1] = 4'hF;
    axi_write(8'h16, 16'h0FFC, 1, 3'd2, BURST_INCR);
    check("edge_bresp", 64'(last_bresp), 64'd2);
    axi_read(8'h26, 16'h0FFC, 1, 3'd2, BURST_INCR, -1, 0);
    check("edge_b1_rdata", 64'(got_r[1]), 64'd0);

    // FIXED burst: both beats land on the same word
    wdat[0] = 32'h000000AA; wstb[0] = 4'hF; wdat[1] = 32'hBB000000; wstb[1] = 4'b1000;
    axi_write(8'h17, 16'h0200, 1, 3'd2, BURST_FIXED);
    axi_read(8'h27, 16'h0200, 1, 3'd2, BURST_FIXED, -1, 0);
    check("fixed_rdata", 64'(got_r[1]), 64'hBB0000AA);

    // Oversize write is dropped; reserved burst still writes but flags SLVERR
    wdat[0] = 32'h55AA55AA; wstb[0] = 4'hF;
    axi_write(8'h18, 16'h0300, 0, 3'd2, BURST_INCR);
    wdat[0] = 32'hFFFFFFFF;
    axi_write(8'h19, 16'h0300, 0, 3'd3, BURST_INCR);
    check("size_bresp", 64'(last_bresp), 64'd2);
    axi_read(8'h28, 16'h0300, 0, 3'd2, BURST_INCR, -1, 0);
    wdat[0] = 32'h01010101; wdat[1] = 32'h02020202; wstb[0] = 4'hF; wstb[1] = 4'hF;
    axi_write(8'h1A, 16'h0400, 1, 3'd2, BURST_RSVD);
    check("rsvd_bresp", 64'(last_bresp), 64'd2);
    axi_read(8'h29, 16'h0400, 1, 3'd2, BURST_INCR, -1, 0);

    // Reset in the middle of a write burst
    bus.awid = 8'h5A; bus.awaddr = 16'h0500; bus.awlen = 8'd3; bus.awsize = 3'd2;
    bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    begin
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.awready && t < TMO);
      check("mid_awready_wait", 64'(bus.awready), 64'd1);
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        bus.wdata = 32'(32'h7700 + i); bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.wready && t < TMO);
        check("mid_wready_wait", 64'(bus.wready), 64'd1);
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_outputs();
    bus.wvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_awready", 64'(bus.awready), 64'd1);
    check("mid_rst_arready", 64'(bus.arready), 64'd1);
    check("mid_rst_wready",  64'(bus.wready),  64'd0);
    check("mid_rst_bvalid",  64'(bus.bvalid),  64'd0);
    @(posedge clk); #1;
    axi_read(8'h2A, 16'h0010, 0, 3'd2, BURST_INCR, -1, 0);
    check("after_rst_rdata", 64'(got_r[0]), 64'hDEADBEEF);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
